// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, bit-timing helpers and RX state encoding.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEF_BAUD_RATE = 9600;
    localparam int unsigned DATA_BITS     = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_bit(
        input int unsigned clk_freq,
        input int unsigned baud_rate
    );
        return clks_per_bit(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; idles (and resets) high.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit search, mid-bit 3-sample majority vote,
// one-cycle rx_done / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    // Start bit is voted around its middle; after realignment the data and
    // stop bits are voted over the last three counts of each bit period.
    localparam logic [CNT_W-1:0] C_S0  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] C_S1  = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] C_S2  = CNT_W'(HALF_BIT + 1);
    localparam logic [CNT_W-1:0] C_D0  = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [CNT_W-1:0] C_D1  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] C_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST  = 3'(DATA_BITS - 1);

    rx_state_e            r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 r_busy;
    logic                 r_s0;
    logic                 r_s1;

    logic w_rx_s;
    logic w_in_bit;
    logic w_pt0;
    logic w_pt1;
    logic w_pt2;
    logic w_vote;

    uart_sync2 u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (rx_in),
        .o_q     (w_rx_s)
    );

    assign w_in_bit = (r_state == RX_DATA) || (r_state == RX_STOP);

    assign w_pt0 = (r_state == RX_START) ? (r_bit_cnt == C_S0)
                                         : (w_in_bit && (r_bit_cnt == C_D0));
    assign w_pt1 = (r_state == RX_START) ? (r_bit_cnt == C_S1)
                                         : (w_in_bit && (r_bit_cnt == C_D1));
    assign w_pt2 = (r_state == RX_START) ? (r_bit_cnt == C_S2)
                                         : (w_in_bit && (r_bit_cnt == C_END));

    assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= RX_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
        end else begin
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_pt0) r_s0 <= w_rx_s;
            if (w_pt1) r_s1 <= w_rx_s;

            unique case (r_state)
                RX_IDLE: begin
                    r_bit_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= RX_START;
                        r_busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (w_pt2) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        if (w_vote) begin
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_pt2) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == LAST) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_pt2) begin
                        r_bit_cnt <= '0;
                        r_state   <= RX_WAIT;
                        r_busy    <= ~w_rx_s;
                        if (w_vote) begin
                            r_data <= r_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                RX_WAIT: begin
                    // A held-low line (break) must go high before re-arming.
                    r_bit_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= RX_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RX_IDLE;
                    r_bit_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign data_rx   = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-banged 8N1 frames, expected bytes from a queue model.
module tb_uart_rx;

    localparam int CF = 3_200_000;
    localparam int BR = 100_000;
    localparam int C  = CF / BR;
    localparam int H  = C / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int n_vec = 0;
    int n_err = 0;

    int         cyc = 0;
    int         n_done = 0;
    int         n_ferr = 0;
    int         n_viol = 0;
    int         done_cyc = 0;
    logic       done_busy = 1'b0;
    logic [7:0] got [0:255];
    logic       prev_d = 1'b0;
    logic       prev_f = 1'b0;

    int         rd = 0;
    logic [7:0] last_byte = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ  (CF),
        .BAUD_RATE (BR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_rx   (data_rx),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes; tasks compare the record against their own model.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            got[n_done % 256] = data_rx;
            n_done++;
            done_cyc  = cyc;
            done_busy = rx_busy;
        end
        if (frame_err === 1'b1) n_ferr++;
        if (rx_done === 1'b1 && frame_err === 1'b1) n_viol++;
        if ((rx_done === 1'b1 && prev_d) || (frame_err === 1'b1 && prev_f))
            n_viol++;
        prev_d = (rx_done === 1'b1);
        prev_f = (frame_err === 1'b1);
    end

    task automatic drive(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(d[i], C);
        drive(stop, C);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({data_rx, rx_done, frame_err, rx_busy} !== 11'h000) begin
            n_err++;
            $display("FAIL reset: got data=%h done=%b ferr=%b busy=%b, want 00 0 0 0",
                     data_rx, rx_done, frame_err, rx_busy);
        end
        rst = 1'b1;
        drive(1'b1, 2 * C);
    endtask

    task automatic test_start_latency;
        logic [7:0] d;
        int t0, base, lat;
        d = 8'($urandom);
        base = n_done;
        rx_in = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_early: got %b want 0", rx_busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (rx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise: got %b want 1", rx_busy);
        end
        drive(1'b0, C - 3);
        for (int i = 0; i < 8; i++) drive(d[i], C);
        drive(1'b1, C);
        n_vec++;
        if (n_done != base + 1 || got[rd] !== d) begin
            n_err++;
            $display("FAIL latency_frame: got %0d frames data=%h want 1 data=%h",
                     n_done - base, got[rd], d);
        end
        lat = done_cyc - t0;
        n_vec++;
        if (lat < 9 * C + H + 2 || lat > 9 * C + H + 6) begin
            n_err++;
            $display("FAIL latency: got %0d cycles want %0d..%0d",
                     lat, 9 * C + H + 2, 9 * C + H + 6);
        end
        n_vec++;
        if (done_busy !== 1'b0 || rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_fall: got at_done=%b now=%b want 0 0",
                     done_busy, rx_busy);
        end
        rd = n_done;
        last_byte = d;
    endtask

    task automatic test_back_to_back;
        logic [7:0] q [$];
        int base, fb;
        q = {8'h55, 8'hA3};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        base = n_done;
        fb = n_ferr;
        foreach (q[i]) send_frame(q[i], 1'b1);
        drive(1'b1, 2 * C);
        n_vec++;
        if (n_done - base != q.size() || n_ferr != fb) begin
            n_err++;
            $display("FAIL b2b_count: got done=%0d ferr=%0d want %0d 0",
                     n_done - base, n_ferr - fb, q.size());
        end
        foreach (q[i]) begin
            n_vec++;
            if (got[base + i] !== q[i]) begin
                n_err++;
                $display("FAIL b2b_data[%0d]: got %h want %h", i, got[base + i], q[i]);
            end
        end
        rd = n_done;
        last_byte = q[q.size() - 1];
    endtask

    task automatic test_frame_err;
        int base, fb;
        base = n_done;
        fb = n_ferr;
        send_frame(8'h00, 1'b0);
        drive(1'b0, 20 * C);
        n_vec++;
        if (n_ferr - fb != 1 || n_done != base) begin
            n_err++;
            $display("FAIL ferr_count: got ferr=%0d done=%0d want 1 0",
                     n_ferr - fb, n_done - base);
        end
        n_vec++;
        if (data_rx !== last_byte || rx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_hold: got data=%h busy=%b want %h 1",
                     data_rx, rx_busy, last_byte);
        end
        drive(1'b1, 2 * C);
        n_vec++;
        if (rx_busy !== 1'b0 || n_ferr - fb != 1 || n_done != base) begin
            n_err++;
            $display("FAIL ferr_release: got busy=%b ferr=%0d done=%0d want 0 1 0",
                     rx_busy, n_ferr - fb, n_done - base);
        end
    endtask

    task automatic test_glitch;
        for (int g = 0; g < 4; g++) begin
            int len, base, fall_at;
            logic seen, fell;
            len = $urandom_range(1, H - 3);
            base = n_done;
            seen = 1'b0;
            fell = 1'b0;
            fall_at = 0;
            rx_in = 1'b0;
            for (int k = 0; k < 3 * C && !fell; k++) begin
                if (k == len) rx_in = 1'b1;
                @(posedge clk); #1;
                if (rx_busy === 1'b1) seen = 1'b1;
                else if (seen) begin
                    fell = 1'b1;
                    fall_at = k + 1;
                end
            end
            rx_in = 1'b1;
            n_vec++;
            if (!seen || !fell || fall_at > H + 8 || n_done != base) begin
                n_err++;
                $display("FAIL glitch(len=%0d): got seen=%b fell=%b at=%0d done=%0d want 1 1 <=%0d 0",
                         len, seen, fell, fall_at, n_done - base, H + 8);
            end
            drive(1'b1, C);
        end
    endtask

    task automatic test_spike;
        int off, base;
        off = $urandom_range(H, H + 2);
        base = n_done;
        drive(1'b0, C);
        for (int i = 0; i < 3; i++) drive(1'b1, C);
        drive(1'b1, off);
        drive(1'b0, 1);
        drive(1'b1, C - off - 1);
        for (int i = 4; i < 8; i++) drive(1'b1, C);
        drive(1'b1, 2 * C);
        n_vec++;
        if (n_done != base + 1 || got[base] !== 8'hFF || data_rx !== 8'hFF) begin
            n_err++;
            $display("FAIL spike(off=%0d): got frames=%0d data=%h want 1 ff",
                     off, n_done - base, data_rx);
        end
        rd = n_done;
        last_byte = 8'hFF;
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        int base, fb;
        d = 8'($urandom) | 8'h01;
        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(d[i], C);
        drive(d[4], H);
        rst = 1'b0;
        rx_in = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({data_rx, rx_done, frame_err, rx_busy} !== 11'h000) begin
            n_err++;
            $display("FAIL mid_reset: got data=%h done=%b ferr=%b busy=%b want 00 0 0 0",
                     data_rx, rx_done, frame_err, rx_busy);
        end
        rst = 1'b1;
        base = n_done;
        fb = n_ferr;
        drive(1'b1, 12 * C);
        n_vec++;
        if (n_done != base || n_ferr != fb) begin
            n_err++;
            $display("FAIL mid_reset_quiet: got done=%0d ferr=%0d want 0 0",
                     n_done - base, n_ferr - fb);
        end
        send_frame(8'h3C, 1'b1);
        drive(1'b1, C);
        n_vec++;
        if (n_done != base + 1 || got[base] !== 8'h3C || data_rx !== 8'h3C) begin
            n_err++;
            $display("FAIL mid_reset_after: got frames=%0d data=%h want 1 3c",
                     n_done - base, data_rx);
        end
        rd = n_done;
        last_byte = 8'h3C;
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        int base, fb, bad, gap;
        logic [7:0] d;
        logic stop;
        base = n_done;
        fb = n_ferr;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            if (stop) begin
                exp_q.push_back(d);
                last_byte = d;
                gap = $urandom_range(0, C);
            end else begin
                bad++;
                gap = $urandom_range(C, 2 * C);
            end
            if (gap > 0) drive(1'b1, gap);
        end
        drive(1'b1, 2 * C);
        n_vec++;
        if (n_done - base != exp_q.size() || n_ferr - fb != bad) begin
            n_err++;
            $display("FAIL rand_count: got done=%0d ferr=%0d want %0d %0d",
                     n_done - base, n_ferr - fb, exp_q.size(), bad);
        end
        foreach (exp_q[i]) begin
            n_vec++;
            if (got[base + i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_data[%0d]: got %h want %h", i, got[base + i], exp_q[i]);
            end
        end
        n_vec++;
        if (data_rx !== last_byte) begin
            n_err++;
            $display("FAIL rand_last: got %h want %h", data_rx, last_byte);
        end
        rd = n_done;
    endtask

    task automatic test_strobe_rules;
        n_vec++;
        if (n_viol != 0) begin
            n_err++;
            $display("FAIL strobe_rules: got %0d overlap/width violations want 0", n_viol);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset;
        test_start_latency;
        test_back_to_back;
        test_frame_err;
        test_glitch;
        test_spike;
        test_reset_midframe;
        test_random;
        test_strobe_rules;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
